// File: rtl/seq_shifter_pkg.sv
// Shared types and constants for the iterative shifter and its 1-bit step datapath.
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-position shift/rotate step; out_bit is the bit ejected from d.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             LR,
    input  logic             AL,
    input  logic             rot,
    output logic [WIDTH-1:0] next_d,
    output logic             out_bit
);

    logic fill;

    // Rotate re-inserts the ejected bit; otherwise left fills zero and right fills per AL.
    always_comb begin
        fill    = 1'b0;
        next_d  = d;
        out_bit = 1'b0;
        if (LR == DIR_LEFT) begin
            out_bit = d[WIDTH-1];
            fill    = rot ? d[WIDTH-1] : 1'b0;
            next_d  = {d[WIDTH-2:0], fill};
        end else begin
            out_bit = d[0];
            fill    = rot ? d[0] : (AL ? d[WIDTH-1] : 1'b0);
            next_d  = {fill, d[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock, start/ready/done handshake,
// registered Moore outputs and a serial output of the last ejected bit.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             LR,
    input  logic             AL,
    input  logic             rot,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             ser_out
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             ser_q, ser_d;
    logic             lr_q, lr_d;
    logic             al_q, al_d;
    logic             rot_q, rot_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_d;
    logic             step_bit;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d       (dout_q),
        .LR      (lr_q),
        .AL      (al_q),
        .rot     (rot_q),
        .next_d  (step_d),
        .out_bit (step_bit)
    );

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        count_d = count_q;
        ser_d   = ser_q;
        lr_d    = lr_q;
        al_d    = al_q;
        rot_d   = rot_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dout_d  = din;
                    count_d = shamt;
                    lr_d    = LR;
                    al_d    = AL;
                    rot_d   = rot;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                dout_d  = step_d;
                ser_d   = step_bit;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake flags are decoded from the next state so they are registered alongside it.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == SHIFT);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dout_q  <= '0;
            count_q <= '0;
            ser_q   <= 1'b0;
            lr_q    <= DIR_RIGHT;
            al_q    <= 1'b0;
            rot_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            ser_q   <= ser_d;
            lr_q    <= lr_d;
            al_q    <= al_d;
            rot_q   <= rot_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign dout    = dout_q;
    assign ser_out = ser_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases, reset abort, back-to-back
// handshake and a randomized sweep against an arithmetic shift/rotate model.
module tb_seq_shifter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] din;
    logic [2:0]   shamt;
    logic         LR;
    logic         AL;
    logic         rot;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         ser_out;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic exp_ser    = 1'b0;

    seq_shifter #(.WIDTH(W), .SHW(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .din     (din),
        .shamt   (shamt),
        .LR      (LR),
        .AL      (AL),
        .rot     (rot),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .dout    (dout),
        .ser_out (ser_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result built from whole-word arithmetic rather than repeated steps.
    function automatic logic [7:0] model_result(input logic [7:0] d, input int s,
                                                input logic lr, input logic al, input logic rt);
        logic [15:0] dd;
        logic [7:0]  r;
        if (s == 0) return d;
        if (rt) begin
            if (lr) begin
                dd = {d, d} << s;
                r  = dd[15:8];
            end else begin
                dd = {d, d} >> s;
                r  = dd[7:0];
            end
        end else if (lr) begin
            r = d << s;
        end else if (al) begin
            r = $signed(d) >>> s;
        end else begin
            r = d >> s;
        end
        return r;
    endfunction

    function automatic logic model_ser(input logic [7:0] d, input int s, input logic lr,
                                       input logic prev);
        if (s == 0) return prev;
        return lr ? d[W - s] : d[s - 1];
    endfunction

    task automatic scramble_inputs();
        start = 1'($urandom);
        din   = 8'($urandom);
        shamt = 3'($urandom);
        LR    = 1'($urandom);
        AL    = 1'($urandom);
        rot   = 1'($urandom);
    endtask

    // Entered at a negedge in IDLE; runs one full operation and checks it.
    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s,
                                 input logic lr, input logic al, input logic rt);
        int           cycles;
        logic [7:0]   exp_dout;
        exp_dout = model_result(d, int'(s), lr, al, rt);
        exp_ser  = model_ser(d, int'(s), lr, exp_ser);
        checkOutput("ready_before_start", 8'(ready), 8'd1);
        din = d; shamt = s; LR = lr; AL = al; rot = rt; start = 1'b1;
        @(negedge clk);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            checkOutput("busy_while_shifting", 8'(busy), 8'd1);
            scramble_inputs();
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", 8'(cycles), 8'(s));
        checkOutput("done_busy_low", 8'(busy), 8'd0);
        checkOutput("done_ready_low", 8'(ready), 8'd0);
        checkOutput("dout", dout, exp_dout);
        checkOutput("ser_out", 8'(ser_out), 8'(exp_ser));
        scramble_inputs();
        @(negedge clk);
        checkOutput("idle_ready", 8'(ready), 8'd1);
        checkOutput("idle_done_low", 8'(done), 8'd0);
        checkOutput("idle_dout_hold", dout, exp_dout);
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] d1;
        logic [7:0] d2;
        rst_n = 1'b0; start = 1'b0; din = '0; shamt = '0; LR = 1'b0; AL = 1'b0; rot = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 8'(ready), 8'd1);
        checkOutput("rst_busy", 8'(busy), 8'd0);
        checkOutput("rst_done", 8'(done), 8'd0);
        checkOutput("rst_dout", dout, 8'h00);
        checkOutput("rst_ser", 8'(ser_out), 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a 7-step logical right shift.
        din = 8'hFF; shamt = 3'd7; LR = 1'b0; AL = 1'b0; rot = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_busy", 8'(busy), 8'd1);
        checkOutput("abort_partial", dout, 8'h1F);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 8'(ready), 8'd1);
        checkOutput("abort_dout", dout, 8'h00);
        checkOutput("abort_busy_low", 8'(busy), 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", 8'(done), 8'd0);
        end
        rst_n = 1'b1;
        exp_ser = 1'b0;
        @(negedge clk);
        checkOutput("abort_no_done_after", 8'(done), 8'd0);

        applyStimulus(8'b1001_0110, 3'd3, 1'b0, 1'b1, 1'b0);
        checkOutput("arith_lit", dout, 8'b1111_0010);
        checkOutput("arith_ser_lit", 8'(ser_out), 8'd1);
        applyStimulus(8'b1001_0110, 3'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("logic_lit", dout, 8'b0001_0010);
        applyStimulus(8'b1001_0110, 3'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("left_lit", dout, 8'b0101_1000);
        checkOutput("left_ser_lit", 8'(ser_out), 8'd0);
        applyStimulus(8'b1001_0110, 3'd1, 1'b0, 1'b1, 1'b1);
        checkOutput("rotr_lit", dout, 8'b0100_1011);
        checkOutput("rotr_ser_lit", 8'(ser_out), 8'd0);
        applyStimulus(8'h81, 3'd7, 1'b1, 1'b0, 1'b1);
        checkOutput("rotl_lit", dout, 8'hC0);
        applyStimulus(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("zero_lit", dout, 8'hA5);

        // start held high across an operation: the next one is taken only from IDLE.
        d1 = 8'h3C; d2 = 8'hE1;
        din = d1; shamt = 3'd2; LR = 1'b1; AL = 1'b0; rot = 1'b0; start = 1'b1;
        @(negedge clk);
        checkOutput("b2b_busy1", 8'(busy), 8'd1);
        din = 8'($urandom); shamt = 3'($urandom);
        @(negedge clk);
        checkOutput("b2b_busy2", 8'(busy), 8'd1);
        din = 8'($urandom); shamt = 3'($urandom);
        @(negedge clk);
        checkOutput("b2b_done1", 8'(done), 8'd1);
        checkOutput("b2b_dout1", dout, model_result(d1, 2, 1'b1, 1'b0, 1'b0));
        din = 8'($urandom); shamt = 3'($urandom);
        @(negedge clk);
        checkOutput("b2b_idle", 8'(ready), 8'd1);
        checkOutput("b2b_idle_dout", dout, model_result(d1, 2, 1'b1, 1'b0, 1'b0));
        din = d2; shamt = 3'd1; LR = 1'b0; AL = 1'b1; rot = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_accept", 8'(busy), 8'd1);
        @(negedge clk);
        checkOutput("b2b_done2", 8'(done), 8'd1);
        checkOutput("b2b_dout2", dout, model_result(d2, 1, 1'b0, 1'b1, 1'b0));
        exp_ser = d2[0];
        checkOutput("b2b_ser2", 8'(ser_out), 8'(exp_ser));
        @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            applyStimulus(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
